// File: rtl/dna_symbol_gen.sv
// Streams SEQ_LEN 2-bit nucleotides decoded LSB-first from PRNG words,
// rewriting any symbol that would extend a homopolymer run beyond MAX_RUN.
module dna_symbol_gen #(
   parameter int unsigned SEQ_LEN = 64,
   parameter int unsigned MAX_RUN = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] rand_in,
   input  logic        start,
   output logic        busy,
   output logic [1:0]  sym_out,
   output logic        sym_valid,
   input  logic        sym_ready,
   output logic        sym_last,
   output logic        done
);

   localparam int unsigned CNT_W = $clog2(SEQ_LEN + 1);
   localparam int unsigned RUN_W = $clog2(MAX_RUN + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SEQ_LEN - 1);
   localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_RUN);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EMIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      shift_q, shift_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic [1:0]       last_sym_q, last_sym_d;
   logic             last_vld_q, last_vld_d;
   logic             busy_q, busy_d;
   logic [1:0]       sym_out_q, sym_out_d;
   logic             sym_valid_q, sym_valid_d;
   logic             sym_last_q, sym_last_d;
   logic             done_q, done_d;

   // Bump the candidate to the next nucleotide when it would exceed the run limit.
   function automatic logic [1:0] pick_sym(input logic [1:0]       cand,
                                           input logic [1:0]       last,
                                           input logic             lvld,
                                           input logic [RUN_W-1:0] run);
      if (lvld && (cand == last) && (run == RUN_MAX)) begin
         return cand + 2'd1;
      end
      return cand;
   endfunction

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      cnt_d      = cnt_q;
      run_d      = run_q;
      last_sym_d = last_sym_q;
      last_vld_d = last_vld_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = EMIT;
               shift_d    = rand_in;
               cnt_d      = '0;
               run_d      = '0;
               last_sym_d = 2'b00;
               last_vld_d = 1'b0;
            end
         end
         EMIT: begin
            if (sym_ready) begin
               run_d      = (last_vld_q && (sym_out_q == last_sym_q)) ?
                            run_q + RUN_W'(1) : RUN_W'(1);
               last_sym_d = sym_out_q;
               last_vld_d = 1'b1;
               if (sym_last_q) begin
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
                  // Refill on the 16th symbol of a word so the stream has no bubble.
                  if ((32'(cnt_q) & 32'd15) == 32'd15) begin
                     shift_d = rand_in;
                  end else begin
                     shift_d = {2'b00, shift_q[31:2]};
                  end
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are registered by deriving them from the next-state values.
      busy_d      = (state_d != IDLE);
      sym_valid_d = (state_d == EMIT);
      sym_last_d  = (state_d == EMIT) && (cnt_d == LAST_IDX);
      sym_out_d   = (state_d == EMIT) ?
                    pick_sym(shift_d[1:0], last_sym_d, last_vld_d, run_d) : 2'b00;
      done_d      = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         cnt_q       <= '0;
         run_q       <= '0;
         last_sym_q  <= 2'b00;
         last_vld_q  <= 1'b0;
         busy_q      <= 1'b0;
         sym_out_q   <= 2'b00;
         sym_valid_q <= 1'b0;
         sym_last_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         run_q       <= run_d;
         last_sym_q  <= last_sym_d;
         last_vld_q  <= last_vld_d;
         busy_q      <= busy_d;
         sym_out_q   <= sym_out_d;
         sym_valid_q <= sym_valid_d;
         sym_last_q  <= sym_last_d;
         done_q      <= done_d;
      end
   end

   assign busy      = busy_q;
   assign sym_out   = sym_out_q;
   assign sym_valid = sym_valid_q;
   assign sym_last  = sym_last_q;
   assign done      = done_q;

endmodule

// File: tb/tb_dna_symbol_gen.sv
// Directed bench for dna_symbol_gen: strand lengths 8, 64 and 1 share one stimulus bus.
module tb_dna_symbol_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] rand_in;
   logic        start;
   logic        sym_ready;

   logic       b8, v8, l8, d8;
   logic [1:0] s8;
   logic       b64, v64, l64, d64;
   logic [1:0] s64;
   logic       b1, v1, l1, d1;
   logic [1:0] s1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dna_symbol_gen #(.SEQ_LEN(8), .MAX_RUN(3)) u8 (
      .clk(clk), .rst(rst), .rand_in(rand_in), .start(start), .busy(b8),
      .sym_out(s8), .sym_valid(v8), .sym_ready(sym_ready), .sym_last(l8), .done(d8));

   dna_symbol_gen #(.SEQ_LEN(64), .MAX_RUN(3)) u64 (
      .clk(clk), .rst(rst), .rand_in(rand_in), .start(start), .busy(b64),
      .sym_out(s64), .sym_valid(v64), .sym_ready(sym_ready), .sym_last(l64), .done(d64));

   dna_symbol_gen #(.SEQ_LEN(1), .MAX_RUN(3)) u1 (
      .clk(clk), .rst(rst), .rand_in(rand_in), .start(start), .busy(b1),
      .sym_out(s1), .sym_valid(v1), .sym_ready(sym_ready), .sym_last(l1), .done(d1));

   typedef struct {
      logic [31:0] word;
      logic [15:0] exp;    // symbol i in bits [2i+1:2i]
      bit          stall;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      start = 1'b0;
      tick();
      rst = 1'b0;
      tick();
   endtask

   // One SEQ_LEN=8 strand with a constant word, optionally with random back-pressure.
   task automatic run8(input logic [31:0] w, input logic [15:0] exp, input bit stall,
                       input string nm);
      int got = 0;
      int cyc = 0;
      logic [1:0] e;
      rand_in = w;
      start = 1'b1;
      sym_ready = 1'b1;
      tick();
      start = 1'b0;
      chk({nm, "_latency"}, 64'(v8), 64'd1);
      while (got < 8 && cyc < 400) begin
         sym_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         e = exp[2*got +: 2];
         if (v8 !== 1'b1) begin
            chk({nm, "_valid"}, 64'(v8), 64'd1);
            break;
         end
         chk({nm, "_sym"}, 64'(s8), 64'(e));
         chk({nm, "_last"}, 64'(l8), 64'(got == 7));
         if (sym_ready) got++;
         cyc++;
         tick();
      end
      chk({nm, "_count"}, 64'(got), 64'd8);
      if (!stall) chk({nm, "_cycles"}, 64'(cyc), 64'd8);
      chk({nm, "_done"}, {61'd0, d8, v8, b8}, 64'b101);
      tick();
      chk({nm, "_idle"}, {62'd0, d8, b8}, 64'd0);
   endtask

   // SEQ_LEN=64 strand with rand_in changing every cycle; words captured on refill edges.
   task automatic run64();
      logic [31:0] word;
      logic [1:0]  mlast, cand, e;
      bit          mvld = 1'b0;
      int          mrun = 0;
      int          got = 0;
      int          cyc = 0;
      rand_in = 32'h1357_9BDF;
      word = rand_in;
      start = 1'b1;
      sym_ready = 1'b1;
      mlast = 2'b00;
      tick();
      start = 1'b0;
      while (got < 64 && cyc < 200) begin
         rand_in = rand_in + 32'd1;
         cand = word[2*(got%16) +: 2];
         e = (mvld && cand == mlast && mrun == 3) ? cand + 2'd1 : cand;
         chk("s64_sym", {61'd0, v64, s64}, {61'd0, 1'b1, e});
         if (got == 63) chk("s64_last", 64'(l64), 64'd1);
         mrun = (mvld && e == mlast) ? mrun + 1 : 1;
         mlast = e;
         mvld = 1'b1;
         if (got % 16 == 15) word = rand_in;
         got++;
         cyc++;
         tick();
      end
      chk("s64_cycles", 64'(cyc), 64'd64);
      chk("s64_done", {62'd0, d64, v64}, 64'b10);
   endtask

   initial begin
      logic [20:0] vbits, dbits;
      int vc, bad, seen_done, seen_busy;

      vecs[0] = '{32'hE4E4_E4E4, 16'hE4E4, 1'b0};
      vecs[1] = '{32'h0000_0000, 16'h4040, 1'b0};
      vecs[2] = '{32'hFFFF_FFFF, 16'h3F3F, 1'b0};
      vecs[3] = '{32'h5555_5555, 16'h9595, 1'b0};
      vecs[4] = '{32'hAAAA_AAAA, 16'hEAEA, 1'b0};
      vecs[5] = '{32'h0000_00F0, 16'h40F0, 1'b0};
      vecs[6] = '{32'h0000_1B1B, 16'h1B1B, 1'b0};
      vecs[7] = '{32'hE4E4_E4E4, 16'hE4E4, 1'b1};
      vecs[8] = '{32'h0000_00F0, 16'h40F0, 1'b1};
      vecs[9] = '{32'h0000_0000, 16'h4040, 1'b1};

      rst = 1'b1;
      start = 1'b0;
      sym_ready = 1'b0;
      rand_in = 32'd0;
      #1;
      chk("reset_async", {58'd0, b8, v8, l8, d8, s8}, 64'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("reset_idle", {58'd0, b8, v8, l8, d8, s8}, 64'd0);

      for (int i = 0; i < 10; i++) begin
         run8(vecs[i].word, vecs[i].exp, vecs[i].stall, $sformatf("vec%0d", i));
      end

      // Consecutive strands start their run count afresh.
      run8(32'h0000_0000, 16'h4040, 1'b0, "norun_carry");

      // Start held high: one IDLE cycle between strands, start ignored while busy.
      rand_in = 32'hE4E4_E4E4;
      sym_ready = 1'b1;
      start = 1'b1;
      vbits = '0;
      dbits = '0;
      vc = 0;
      bad = 0;
      for (int j = 0; j < 21; j++) begin
         tick();
         vbits[j] = v8;
         dbits[j] = d8;
         if (v8) begin
            if (s8 !== 2'(vc % 4)) bad++;
            vc++;
         end
      end
      start = 1'b0;
      chk("b2b_valid", 64'(vbits), 64'h13_FCFF);
      chk("b2b_done", 64'(dbits), 64'h4_0100);
      chk("b2b_sym", 64'(bad), 64'd0);

      do_reset();
      run64();

      do_reset();
      rand_in = 32'hE4E4_E4E7;
      sym_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("len1_first", {60'd0, v1, l1, s1}, 64'b1111);
      tick();
      chk("len1_done", {61'd0, d1, v1, b1}, 64'b101);

      // Reset in the middle of a strand aborts it without a done pulse.
      do_reset();
      rand_in = 32'h0000_0000;
      sym_ready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      chk("mid_sym5", {61'd0, v8, s8}, 64'b100);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_async", {58'd0, b8, v8, l8, d8, s8}, 64'd0);
      tick();
      chk("mid_rst_hold", {58'd0, b8, v8, l8, d8, s8}, 64'd0);
      rst = 1'b0;
      seen_done = 0;
      seen_busy = 0;
      for (int j = 0; j < 12; j++) begin
         tick();
         if (d8) seen_done++;
         if (b8) seen_busy++;
      end
      chk("mid_no_done", 64'(seen_done), 64'd0);
      chk("mid_wait_idle", 64'(seen_busy), 64'd0);
      run8(32'h0000_0000, 16'h4040, 1'b0, "mid_fresh");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
